// File: rtl/spawn_scheduler_if.sv
// Spawn request handshake between spawn_scheduler (master) and event_core (slave).
interface spawn_scheduler_if;
  logic spawn_valid;
  logic spawn_ready;

  modport master (output spawn_valid, input spawn_ready);
  modport slave  (input spawn_valid, output spawn_ready);
endinterface

// File: rtl/spawn_scheduler.sv
// Paces alien spawns into event_core with per-level interval/burst credits.
// Optional macro SPAWN_IMMEDIATE_EN preloads one burst of credits at level start.
module spawn_scheduler #(
  parameter int unsigned BASE_INTERVAL = 50,
  parameter int unsigned INTERVAL_STEP = 5,
  parameter int unsigned MIN_INTERVAL  = 15,
  parameter int unsigned MAX_PENDING   = 7,
  parameter int unsigned OBJ_LIMIT     = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                level_start,
  input  logic [3:0]          cur_level,
  input  logic                tick,
  input  logic                script_ended,
  input  logic [3:0]          object_count,
  spawn_scheduler_if.master   spawn,
  output logic [2:0]          pending,
  output logic [7:0]          spawn_total,
  output logic [1:0]          sched_state
);

  localparam logic [7:0] BASE8     = 8'(BASE_INTERVAL);
  localparam logic [7:0] STEP8     = 8'(INTERVAL_STEP);
  localparam logic [7:0] MIN8      = 8'(MIN_INTERVAL);
  localparam logic [3:0] MAXPEND4  = 4'(MAX_PENDING);
  localparam logic [4:0] OBJLIM5   = 5'(OBJ_LIMIT);

  typedef enum logic [1:0] {IDLE = 2'd0, ACTIVE = 2'd1, DONE = 2'd2} state_t;

  state_t     state;
  logic [7:0] tick_cnt;
  logic [7:0] interval_q;
  logic [2:0] burst_q;

  function automatic logic [7:0] calc_interval(input logic [3:0] lvl);
    logic [7:0] lv;
    logic [7:0] dec;
    logic [7:0] diff;
    lv   = (lvl > 4'd7) ? 8'd7 : {4'd0, lvl};
    dec  = lv * STEP8;
    // Guard the subtraction so a large step never wraps the interval.
    diff = (BASE8 > dec) ? (BASE8 - dec) : 8'd0;
    return (diff < MIN8) ? MIN8 : diff;
  endfunction

  function automatic logic [2:0] sat_pending(input logic [3:0] v);
    return (v > MAXPEND4) ? MAXPEND4[2:0] : v[2:0];
  endfunction

  function automatic logic [7:0] sat_total(input logic [7:0] v, input logic inc);
    return (inc && (v != 8'hFF)) ? (v + 8'd1) : v;
  endfunction

  logic [7:0] interval_cfg;
  logic [2:0] burst_cfg;
  logic       xfer;
  logic       credit;
  logic [2:0] pend_act;
  logic       below_cap;

  always_comb begin
    interval_cfg = calc_interval(cur_level);
    burst_cfg    = 3'd1 + {1'b0, cur_level[3:2]};
    xfer         = spawn.spawn_valid & spawn.spawn_ready;
    credit       = tick && (tick_cnt == (interval_q - 8'd1));
    // valid implies pending > 0, so the transfer decrement never underflows.
    pend_act     = sat_pending({1'b0, pending} + (credit ? {1'b0, burst_q} : 4'd0)
                               - {3'd0, xfer});
    below_cap    = {1'b0, object_count} < OBJLIM5;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      tick_cnt          <= 8'd0;
      interval_q        <= 8'd0;
      burst_q           <= 3'd0;
      pending           <= 3'd0;
      spawn_total       <= 8'd0;
      spawn.spawn_valid <= 1'b0;
    end else if (!en) begin
      state             <= IDLE;
      tick_cnt          <= 8'd0;
      pending           <= 3'd0;
      spawn.spawn_valid <= 1'b0;
    end else if (level_start) begin
      state             <= ACTIVE;
      tick_cnt          <= 8'd0;
      interval_q        <= interval_cfg;
      burst_q           <= burst_cfg;
      spawn_total       <= 8'd0;
      spawn.spawn_valid <= 1'b0;
`ifdef SPAWN_IMMEDIATE_EN
      pending           <= sat_pending({1'b0, burst_cfg});
`else
      pending           <= 3'd0;
`endif
    end else begin
      case (state)
        ACTIVE: begin
          spawn_total <= sat_total(spawn_total, xfer);
          if (tick) tick_cnt <= credit ? 8'd0 : (tick_cnt + 8'd1);
          if (script_ended) begin
            state             <= DONE;
            pending           <= 3'd0;
            spawn.spawn_valid <= 1'b0;
          end else begin
            pending           <= pend_act;
            spawn.spawn_valid <= (pend_act != 3'd0) && below_cap;
          end
        end
        DONE: begin
          pending           <= 3'd0;
          spawn.spawn_valid <= 1'b0;
        end
        default: begin
          pending           <= 3'd0;
          spawn.spawn_valid <= 1'b0;
        end
      endcase
    end
  end

  assign sched_state = state;

endmodule

// File: tb/tb_spawn_scheduler.sv
// Directed self-checking bench for spawn_scheduler.
module tb_spawn_scheduler;
  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       level_start;
  logic [3:0] cur_level;
  logic       tick;
  logic       script_ended;
  logic [3:0] object_count;
  logic [2:0] pending;
  logic [7:0] spawn_total;
  logic [1:0] sched_state;
  int tests = 0;
  int fails = 0;

  spawn_scheduler_if sif ();

  spawn_scheduler dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .level_start  (level_start),
    .cur_level    (cur_level),
    .tick         (tick),
    .script_ended (script_ended),
    .object_count (object_count),
    .spawn        (sif),
    .pending      (pending),
    .spawn_total  (spawn_total),
    .sched_state  (sched_state)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_tick();
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    cyc();
  endtask

  task automatic start_level(input logic [3:0] lvl);
    cur_level   = lvl;
    level_start = 1'b1;
    cyc();
    level_start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc();
    cyc();
    tests++;
    if (sched_state !== 2'd0 || pending !== 3'd0 || spawn_total !== 8'd0 || sif.spawn_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset: state=%0d pending=%0d total=%0d valid=%0d, want all 0",
               sched_state, pending, spawn_total, sif.spawn_valid);
    end
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_level0();
    sif.spawn_ready = 1'b1;
    start_level(4'd0);
    tests++;
    if (sched_state !== 2'd1 || pending !== 3'd0) begin
      fails++;
      $display("FAIL l0_start: state=%0d pending=%0d, want 1 0", sched_state, pending);
    end
    for (int i = 0; i < 49; i++) do_tick();
    tests++;
    if (pending !== 3'd0 || sif.spawn_valid !== 1'b0) begin
      fails++;
      $display("FAIL l0_49ticks: pending=%0d valid=%0d, want 0 0", pending, sif.spawn_valid);
    end
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    tests++;
    if (pending !== 3'd1 || sif.spawn_valid !== 1'b1) begin
      fails++;
      $display("FAIL l0_credit: pending=%0d valid=%0d, want 1 1", pending, sif.spawn_valid);
    end
    cyc();
    tests++;
    if (pending !== 3'd0 || spawn_total !== 8'd1 || sif.spawn_valid !== 1'b0) begin
      fails++;
      $display("FAIL l0_xfer: pending=%0d total=%0d valid=%0d, want 0 1 0",
               pending, spawn_total, sif.spawn_valid);
    end
  endtask

  task automatic test_saturation();
    int lowcnt;
    logic [2:0] exp;
    lowcnt = 0;
    sif.spawn_ready = 1'b0;
    start_level(4'd5);
    for (int i = 1; i <= 100; i++) begin
      do_tick();
      if (i >= 25 && sif.spawn_valid !== 1'b1) lowcnt++;
      if (i % 25 == 0) begin
        exp = (i == 25) ? 3'd2 : (i == 50) ? 3'd4 : (i == 75) ? 3'd6 : 3'd7;
        tests++;
        if (pending !== exp) begin
          fails++;
          $display("FAIL sat_pending tick%0d: pending=%0d, want %0d", i, pending, exp);
        end
      end
    end
    tests++;
    if (lowcnt != 0 || spawn_total !== 8'd0) begin
      fails++;
      $display("FAIL sat_valid_held: low_cycles=%0d total=%0d, want 0 0", lowcnt, spawn_total);
    end
  endtask

  task automatic test_obj_cap();
    sif.spawn_ready = 1'b0;
    object_count = 4'd8;
    start_level(4'd9);
    for (int i = 0; i < 15; i++) do_tick();
    tests++;
    if (pending !== 3'd3 || sif.spawn_valid !== 1'b0) begin
      fails++;
      $display("FAIL cap_blocked: pending=%0d valid=%0d, want 3 0", pending, sif.spawn_valid);
    end
    object_count = 4'd7;
    cyc();
    tests++;
    if (sif.spawn_valid !== 1'b1) begin
      fails++;
      $display("FAIL cap_release: valid=%0d, want 1", sif.spawn_valid);
    end
    sif.spawn_ready = 1'b1;
    cyc();
    tests++;
    if (pending !== 3'd2 || spawn_total !== 8'd1) begin
      fails++;
      $display("FAIL cap_xfer1: pending=%0d total=%0d, want 2 1", pending, spawn_total);
    end
    cyc();
    cyc();
    tests++;
    if (pending !== 3'd0 || spawn_total !== 8'd3 || sif.spawn_valid !== 1'b0) begin
      fails++;
      $display("FAIL cap_xfer3: pending=%0d total=%0d valid=%0d, want 0 3 0",
               pending, spawn_total, sif.spawn_valid);
    end
    sif.spawn_ready = 1'b0;
    object_count = 4'd0;
  endtask

  task automatic test_credit_xfer();
    sif.spawn_ready = 1'b0;
    start_level(4'd12);
    for (int i = 0; i < 29; i++) do_tick();
    tests++;
    if (pending !== 3'd4) begin
      fails++;
      $display("FAIL cx_setup: pending=%0d, want 4", pending);
    end
    sif.spawn_ready = 1'b1;
    cyc();
    cyc();
    tests++;
    if (pending !== 3'd2 || sif.spawn_valid !== 1'b1) begin
      fails++;
      $display("FAIL cx_pend2: pending=%0d valid=%0d, want 2 1", pending, sif.spawn_valid);
    end
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    sif.spawn_ready = 1'b0;
    tests++;
    if (pending !== 3'd5 || spawn_total !== 8'd3 || sif.spawn_valid !== 1'b1) begin
      fails++;
      $display("FAIL cx_both: pending=%0d total=%0d valid=%0d, want 5 3 1",
               pending, spawn_total, sif.spawn_valid);
    end
  endtask

  task automatic test_script_end();
    sif.spawn_ready = 1'b0;
    start_level(4'd12);
    for (int i = 0; i < 15; i++) do_tick();
    script_ended = 1'b1;
    sif.spawn_ready = 1'b1;
    cyc();
    script_ended = 1'b0;
    sif.spawn_ready = 1'b0;
    tests++;
    if (sched_state !== 2'd2 || pending !== 3'd0 || sif.spawn_valid !== 1'b0 || spawn_total !== 8'd1) begin
      fails++;
      $display("FAIL se_done: state=%0d pending=%0d valid=%0d total=%0d, want 2 0 0 1",
               sched_state, pending, sif.spawn_valid, spawn_total);
    end
    sif.spawn_ready = 1'b1;
    for (int i = 0; i < 20; i++) do_tick();
    sif.spawn_ready = 1'b0;
    tests++;
    if (sched_state !== 2'd2 || pending !== 3'd0 || sif.spawn_valid !== 1'b0 || spawn_total !== 8'd1) begin
      fails++;
      $display("FAIL se_hold: state=%0d pending=%0d valid=%0d total=%0d, want 2 0 0 1",
               sched_state, pending, sif.spawn_valid, spawn_total);
    end
    start_level(4'd12);
    tests++;
    if (sched_state !== 2'd1 || spawn_total !== 8'd0) begin
      fails++;
      $display("FAIL se_restart: state=%0d total=%0d, want 1 0", sched_state, spawn_total);
    end
  endtask

  task automatic test_disable();
    sif.spawn_ready = 1'b0;
    start_level(4'd9);
    for (int i = 0; i < 15; i++) do_tick();
    sif.spawn_ready = 1'b1;
    cyc();
    sif.spawn_ready = 1'b0;
    en = 1'b0;
    cyc();
    tests++;
    if (sched_state !== 2'd0 || pending !== 3'd0 || sif.spawn_valid !== 1'b0 || spawn_total !== 8'd1) begin
      fails++;
      $display("FAIL dis_idle: state=%0d pending=%0d valid=%0d total=%0d, want 0 0 0 1",
               sched_state, pending, sif.spawn_valid, spawn_total);
    end
    en = 1'b1;
    for (int i = 0; i < 20; i++) do_tick();
    tests++;
    if (sched_state !== 2'd0 || pending !== 3'd0 || sif.spawn_valid !== 1'b0) begin
      fails++;
      $display("FAIL dis_ignore: state=%0d pending=%0d valid=%0d, want 0 0 0",
               sched_state, pending, sif.spawn_valid);
    end
  endtask

  task automatic test_reset_mid();
    sif.spawn_ready = 1'b0;
    start_level(4'd9);
    for (int i = 0; i < 15; i++) do_tick();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    tests++;
    if (sched_state !== 2'd0 || pending !== 3'd0 || spawn_total !== 8'd0 || sif.spawn_valid !== 1'b0) begin
      fails++;
      $display("FAIL rst_mid: state=%0d pending=%0d total=%0d valid=%0d, want all 0",
               sched_state, pending, spawn_total, sif.spawn_valid);
    end
  endtask

  task automatic test_immediate();
    sif.spawn_ready = 1'b0;
    start_level(4'd4);
    tests++;
    if (sched_state !== 2'd1 || pending !== 3'd2 || sif.spawn_valid !== 1'b0) begin
      fails++;
      $display("FAIL imm_preload: state=%0d pending=%0d valid=%0d, want 1 2 0",
               sched_state, pending, sif.spawn_valid);
    end
    cyc();
    tests++;
    if (sif.spawn_valid !== 1'b1) begin
      fails++;
      $display("FAIL imm_valid: valid=%0d, want 1", sif.spawn_valid);
    end
  endtask

  initial begin
    rst = 1'b1;
    en = 1'b1;
    level_start = 1'b0;
    cur_level = 4'd0;
    tick = 1'b0;
    script_ended = 1'b0;
    object_count = 4'd0;
    sif.spawn_ready = 1'b0;
    test_reset();
`ifdef SPAWN_IMMEDIATE_EN
    test_immediate();
`else
    test_level0();
    test_saturation();
    test_obj_cap();
    test_credit_xfer();
    test_script_end();
    test_disable();
`endif
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
